pipearch_fetch: RTL and testbench
=================================

// Module: pipearch_fetch
// PURPOSE
//  - Read-side counterpart of the CCI-P channel-1 writeback engine: streams a block of cache lines from host memory into an on-chip BRAM.
//  - Issues CCI-P c0 RDLINE requests and accepts out-of-order c0 responses.
//  - Writes each returned line to the BRAM at its line index; pulses op_done once every line has landed.
//  - Sits between the CCI-P c0 port and the model/sample BRAMs; sequenced by the PipeArch instruction engine via op_start.
// PARAMETERS
//  ADDR_WIDTH       10  BRAM word-address width (one word = one 512b line)
//  MAX_OUTSTANDING  64  in-flight read cap; used only with PIPEARCH_FETCH_CREDIT_EN
// PORTS
//  clk             in   1           core clock, single domain
//  reset           in   1           asynchronous, active-low (0 = in reset)
//  op_start        in   1           1-cycle start pulse; sampled only in IDLE
//  op_done         out  1           1-cycle completion pulse
//  regs            in   32xNUM_REGS config registers (see CONFIGURATION)
//  in_addr         in   t_ccip_clAddr   input buffer base line address
//  out_addr        in   t_ccip_clAddr   output buffer base line address
//  mem_output      --   fifobram_interface.bram_write   BRAM write port (we, waddr, wdata[511:0])
//  c0TxAlmFull     in   1           CCI-P c0 request back-pressure
//  cp2af_sRx_c0    in   t_if_ccip_c0_Rx   read responses
//  af2cp_sTx_c0    out  t_if_ccip_c0_Tx   read requests
// BEHAVIOUR
//  - Reset values: op_done=0, af2cp_sTx_c0.valid=0, mem_output.we=0, both FSMs IDLE, all counters 0.
//  - Two FSMs, IDLE->ACTIVE->DONE->IDLE: request FSM and response FSM. Both leave IDLE on the same op_start.
//  - op_start in IDLE: latch base = (regs[0][31]==0) ? in_addr+regs[0] : out_addr+regs[0], length = regs[1][15:0], bram_off = regs[2][ADDR_WIDTH-1:0].
//    - length==0: both FSMs go straight to DONE. op_done is high 2 cycles after op_start; no requests, no writes.
//  - Request FSM (ACTIVE):
//    - Issues when !c0TxAlmFull (and a credit is available, if enabled).
//    - Registered outputs: valid=1; hdr = eREQ_RDLINE_I, eVC_VA, eCL_LEN_1; address = base+req_cnt; mdata[15:0] = req_cnt.
//    - req_cnt increments on each issue. After the issue with req_cnt==length-1, go to DONE, then IDLE the next cycle.
//    - valid is a 1-cycle pulse per request; default 0.
//  - Response FSM (ACTIVE):
//    - Acts on rspValid && resp_type==eRSP_RDLINE. Next cycle: we=1, waddr = bram_off+mdata[ADDR_WIDTH-1:0] (mod 2^ADDR_WIDTH), wdata = rsp data.
//    - rsp_cnt increments on each such response. The response with rsp_cnt==length-1 moves to DONE.
//    - op_done=1 in the DONE cycle, i.e. 2 cycles after the last response and 1 cycle after its BRAM write.
//  - Out-of-order: placement is by mdata only; arrival order is irrelevant.
//  - Simultaneous request issue and response in one cycle: both are processed.
//  - Responses arriving while the response FSM is IDLE/DONE, and non-RDLINE responses, are ignored (no write, no count).
//  - op_start while either FSM is not IDLE: ignored.
//  - Reset mid-operation: immediate return to reset values; stale responses after reset fall under the IDLE-drop rule.
//  - length > 2^ADDR_WIDTH: BRAM address wraps and later lines overwrite earlier ones; op_done still waits for all length responses.
//  - Counters are 16 bit; length max 65535.
// CONFIGURATION
//  - Macro PIPEARCH_FETCH_CREDIT_EN.
//  - Defined:
//    - in-flight counter = issued - received, 0..MAX_OUTSTANDING.
//    - Request issue is blocked while in_flight==MAX_OUTSTANDING.
//    - Issue and response in the same cycle leave the count unchanged.
//  - Undefined: no in-flight counter; issue is gated by c0TxAlmFull only; MAX_OUTSTANDING is unused.
// STRUCTURE
//  - pipearch_common.vh (shared package):
//    - typedef t_fetchstate {STATE_IDLE, STATE_ACTIVE, STATE_DONE} (logic [1:0]);
//    - register index constants FETCH_REG_OFFSET=0, FETCH_REG_LENGTH=1, FETCH_REG_BRAMOFF=2.
//  - Header builder is an always_comb in-module.
//  - One natural sub-module: pipearch_fetch_credit (in-flight counter plus can_issue flag), instantiated only under PIPEARCH_FETCH_CREDIT_EN.
// TESTING
//  1. length=0, op_start -> op_done high exactly 2 cycles later; no c0 valid, no BRAM we.
//  2. regs[0]=0x10, in_addr=0x1000, length=4, in-order responses ->
//     - requests to 0x1010..0x1013 with mdata 0..3;
//     - BRAM words bram_off+0..3 hold the returned data;
//     - op_done 2 cycles after the 4th response.
//  3. length=8, responses returned in order 7,0,5,2,1,6,3,4 -> every line lands at bram_off+mdata; op_done after the 8th response only.
//  4. c0TxAlmFull held high 10 cycles mid-stream -> no valid while high; issue resumes with no skipped or duplicated address.
//  5. CREDIT_EN, MAX_OUTSTANDING=4, length=16, responses withheld -> exactly 4 requests issued; each response releases exactly 1 more.
//  6. reset driven low after 3 of 8 responses, then released; late responses injected -> no BRAM writes, op_done stays 0; a new op_start then runs cleanly.

Source files
------------

// File: rtl/pipearch_fetch_pkg.sv
// pipearch_fetch_pkg: shared FSM state type, config register indices and the CCI-P c0 channel types used by the fetch engine
package pipearch_fetch_pkg;
  typedef enum logic [1:0] {STATE_IDLE, STATE_ACTIVE, STATE_DONE} t_fetchstate;
  localparam int FETCH_REG_OFFSET = 0;
  localparam int FETCH_REG_LENGTH = 1;
  localparam int FETCH_REG_BRAMOFF = 2;
  localparam int NUM_REGS = 4;
  typedef logic [41:0] t_ccip_clAddr;
  typedef logic [15:0] t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;
  typedef enum logic [1:0] {eVC_VA = 2'b00, eVC_VL0 = 2'b01, eVC_VH0 = 2'b10, eVC_VH1 = 2'b11} t_ccip_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_clLen;
  typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
  typedef struct packed {
    t_ccip_vc     vc_sel;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;
  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;
  typedef struct packed {
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;
  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
  } t_if_ccip_c0_Rx;
endpackage

// File: rtl/fifobram_interface.sv
// fifobram_interface: one-line-per-word BRAM write port (we, waddr, wdata) shared by the fetch/writeback engines
//   bram_write: producer side (drives we/waddr/wdata)
//   bram_read : observer side
interface fifobram_interface #(parameter int ADDR_WIDTH = 10);
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [511:0]          wdata;
  modport bram_write(output we, waddr, wdata);
  modport bram_read(input we, waddr, wdata);
endinterface

// File: rtl/pipearch_fetch_credit.sv
// pipearch_fetch_credit: in-flight read counter (issued - received) with an issue-permit flag
//   clk, reset (async, active-low), issue/retire (1 per event), can_issue (count below MAX_OUTSTANDING)
module pipearch_fetch_credit #(
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  input  logic retire,
  output logic can_issue
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // a retire with nothing in flight (stray response) must not wrap the count
  always_comb cnt_d = (retire && !issue && cnt_q == '0) ? cnt_q : cnt_q + CW'(issue) - CW'(retire);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign can_issue = cnt_q != CW'(MAX_OUTSTANDING);
endmodule

// File: rtl/pipearch_fetch.sv
// pipearch_fetch: streams a block of cache lines from host memory (CCI-P c0 RDLINE) into an on-chip BRAM, out-of-order safe
//   clk, reset (async, active-low), op_start -> op_done (1-cycle pulses)
//   regs[0] line offset (bit31 selects out_addr), regs[1][15:0] length, regs[2] BRAM offset
//   in_addr/out_addr base lines, mem_output BRAM write port
//   c0TxAlmFull, cp2af_sRx_c0 (responses), af2cp_sTx_c0 (requests)
//   Macro PIPEARCH_FETCH_CREDIT_EN caps in-flight reads at MAX_OUTSTANDING.
module pipearch_fetch
  import pipearch_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         op_start,
  output logic                         op_done,
  input  logic [31:0]                  regs [NUM_REGS],
  input  t_ccip_clAddr                 in_addr,
  input  t_ccip_clAddr                 out_addr,
  fifobram_interface.bram_write        mem_output,
  input  logic                         c0TxAlmFull,
  input  t_if_ccip_c0_Rx               cp2af_sRx_c0,
  output t_if_ccip_c0_Tx               af2cp_sTx_c0
);
  t_fetchstate req_state_q, req_state_d, rsp_state_q, rsp_state_d;
  t_ccip_clAddr base_q, base_d;
  logic [15:0] len_q, len_d, req_cnt_q, req_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic [ADDR_WIDTH-1:0] off_q, off_d, waddr_q, waddr_d;
  t_ccip_clData wdata_q, wdata_d;
  logic we_q, we_d, done_q, done_d;
  t_if_ccip_c0_Tx tx_q, tx_d;
  t_ccip_c0_ReqMemHdr req_hdr;
  logic start, len_zero, can_issue, issue, rsp_ok, unused_bits;

  assign start = op_start && req_state_q == STATE_IDLE && rsp_state_q == STATE_IDLE;
  assign len_zero = regs[FETCH_REG_LENGTH][15:0] == 16'd0;
  assign issue = req_state_q == STATE_ACTIVE && !c0TxAlmFull && can_issue;
  assign rsp_ok = rsp_state_q == STATE_ACTIVE && cp2af_sRx_c0.rspValid && cp2af_sRx_c0.hdr.resp_type == eRSP_RDLINE;
  assign unused_bits = ^{regs[FETCH_REG_LENGTH][31:16], regs[FETCH_REG_BRAMOFF][31:ADDR_WIDTH], cp2af_sRx_c0.hdr.mdata[15:ADDR_WIDTH]};

`ifdef PIPEARCH_FETCH_CREDIT_EN
  pipearch_fetch_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
    .clk(clk),
    .reset(reset),
    .issue(issue),
    .retire(rsp_ok),
    .can_issue(can_issue)
  );
`else
  logic [31:0] unused_max;
  assign unused_max = 32'(MAX_OUTSTANDING);
  assign can_issue = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_state_q <= STATE_IDLE;
      rsp_state_q <= STATE_IDLE;
      base_q <= '0;
      len_q <= '0;
      off_q <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      tx_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q <= 1'b0;
    end else begin
      req_state_q <= req_state_d;
      rsp_state_q <= rsp_state_d;
      base_q <= base_d;
      len_q <= len_d;
      off_q <= off_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      tx_q <= tx_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q <= done_d;
    end
  end

  // both FSMs leave IDLE on the same start; a zero-length op skips straight to DONE
  always_comb begin
    req_state_d = req_state_q;
    rsp_state_d = rsp_state_q;
    case (req_state_q)
      STATE_IDLE:   req_state_d = start ? (len_zero ? STATE_DONE : STATE_ACTIVE) : STATE_IDLE;
      STATE_ACTIVE: req_state_d = (issue && req_cnt_q == len_q - 16'd1) ? STATE_DONE : STATE_ACTIVE;
      default:      req_state_d = STATE_IDLE;
    endcase
    case (rsp_state_q)
      STATE_IDLE:   rsp_state_d = start ? (len_zero ? STATE_DONE : STATE_ACTIVE) : STATE_IDLE;
      STATE_ACTIVE: rsp_state_d = (rsp_ok && rsp_cnt_q == len_q - 16'd1) ? STATE_DONE : STATE_ACTIVE;
      default:      rsp_state_d = STATE_IDLE;
    endcase
  end

  always_comb begin
    base_d = start ? (regs[FETCH_REG_OFFSET][31] ? out_addr : in_addr) + t_ccip_clAddr'(regs[FETCH_REG_OFFSET]) : base_q;
    len_d = start ? regs[FETCH_REG_LENGTH][15:0] : len_q;
    off_d = start ? regs[FETCH_REG_BRAMOFF][ADDR_WIDTH-1:0] : off_q;
    req_cnt_d = start ? '0 : req_cnt_q + 16'(issue);
    rsp_cnt_d = start ? '0 : rsp_cnt_q + 16'(rsp_ok);
  end

  always_comb begin
    req_hdr = '0;
    req_hdr.vc_sel = eVC_VA;
    req_hdr.cl_len = eCL_LEN_1;
    req_hdr.req_type = eREQ_RDLINE_I;
    req_hdr.address = base_q + t_ccip_clAddr'(req_cnt_q);
    req_hdr.mdata = req_cnt_q;
  end

  // placement is purely by the returned mdata, so arrival order does not matter
  always_comb begin
    tx_d.valid = issue;
    tx_d.hdr = req_hdr;
    we_d = rsp_ok;
    waddr_d = off_q + cp2af_sRx_c0.hdr.mdata[ADDR_WIDTH-1:0];
    wdata_d = cp2af_sRx_c0.data;
    done_d = rsp_state_q == STATE_DONE;
  end

  assign af2cp_sTx_c0 = tx_q;
  assign op_done = done_q;
  assign mem_output.we = we_q;
  assign mem_output.waddr = waddr_q;
  assign mem_output.wdata = wdata_q;
endmodule

// File: tb/tb_pipearch_fetch.sv
// tb_pipearch_fetch: directed self-checking bench for the c0 line fetch engine
module tb_pipearch_fetch;
  import pipearch_fetch_pkg::*;
  localparam int AW = 10;
  localparam int MAXO = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic op_start = 1'b0;
  logic op_done;
  logic alm = 1'b0;
  logic [31:0] regs [NUM_REGS];
  t_ccip_clAddr in_addr, out_addr;
  t_if_ccip_c0_Rx rx;
  t_if_ccip_c0_Tx tx;
  fifobram_interface #(.ADDR_WIDTH(AW)) mem_if ();
  int checks = 0;
  int errors = 0;
  int req_n = 0;
  int wr_n = 0;
  int done_n = 0;
  t_ccip_clAddr req_addr [64];
  logic [15:0] req_md [64];
  logic [511:0] bram [1024];

  always #5 clk = ~clk;

  pipearch_fetch #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk),
    .reset(reset),
    .op_start(op_start),
    .op_done(op_done),
    .regs(regs),
    .in_addr(in_addr),
    .out_addr(out_addr),
    .mem_output(mem_if),
    .c0TxAlmFull(alm),
    .cp2af_sRx_c0(rx),
    .af2cp_sTx_c0(tx)
  );

  always @(posedge clk) begin
    #1;
    if (tx.valid) begin
      if (req_n < 64) begin
        req_addr[req_n] = tx.hdr.address;
        req_md[req_n] = tx.hdr.mdata;
      end
      req_n++;
    end
    if (mem_if.we) begin
      bram[mem_if.waddr] = mem_if.wdata;
      wr_n++;
    end
    if (op_done) done_n++;
  end

  function automatic logic [511:0] pat(input logic [15:0] seed, input logic [15:0] md);
    return {8{seed, 32'h0, md}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_op(input logic [31:0] r0, input logic [15:0] len, input logic [AW-1:0] off);
    regs[0] = r0;
    regs[1] = {16'h0, len};
    regs[2] = {22'h0, off};
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic respond(input logic [15:0] md, input logic [15:0] seed, input t_ccip_c0_rsp typ);
    rx.rspValid = 1'b1;
    rx.hdr.resp_type = typ;
    rx.hdr.mdata = md;
    rx.data = pat(seed, md);
    @(negedge clk);
    rx.rspValid = 1'b0;
  endtask

  task automatic wait_req(input int n);
    for (int k = 0; k < 300 && req_n < n; k++) @(negedge clk);
    chk("wait_req", 512'(req_n), 512'(n));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rb, w0, d0;
    int ord [8] = '{7, 0, 5, 2, 1, 6, 3, 4};
    logic [AW-1:0] a;
    rx = '0;
    regs[0] = '0;
    regs[1] = '0;
    regs[2] = '0;
    regs[3] = '0;
    in_addr = 42'h1000;
    out_addr = 42'h2000;
    tick(3);
    chk("rst_done", 512'(op_done), 512'(0));
    chk("rst_valid", 512'(tx.valid), 512'(0));
    chk("rst_we", 512'(mem_if.we), 512'(0));
    reset = 1'b1;
    tick(2);
    // zero length: done exactly two cycles after start, nothing issued or written
    start_op(32'h0, 16'd0, '0);
    chk("len0_done_c1", 512'(op_done), 512'(0));
    tick(1);
    chk("len0_done_c2", 512'(op_done), 512'(1));
    tick(1);
    chk("len0_done_c3", 512'(op_done), 512'(0));
    tick(3);
    chk("len0_reqs", 512'(req_n), 512'(0));
    chk("len0_writes", 512'(wr_n), 512'(0));
    // length 4, in order
    rb = req_n;
    start_op(32'h10, 16'd4, 10'h20);
    wait_req(rb + 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", 512'(req_addr[rb + i]), 512'(42'h1010 + 42'(i)));
      chk("t2_mdata", 512'(req_md[rb + i]), 512'(i));
    end
    w0 = wr_n;
    respond(16'd0, 16'hBAD, eRSP_UMSG);
    tick(2);
    chk("umsg_ignored", 512'(wr_n), 512'(w0));
    for (int i = 0; i < 4; i++) respond(16'(i), 16'h2, eRSP_RDLINE);
    chk("t2_done_early", 512'(op_done), 512'(0));
    tick(1);
    chk("t2_done", 512'(op_done), 512'(1));
    tick(1);
    for (int i = 0; i < 4; i++) chk("t2_bram", bram[10'h20 + 10'(i)], pat(16'h2, 16'(i)));
    chk("t2_reqs_total", 512'(req_n), 512'(rb + 4));
    // length 8, out of order, BRAM offset wraps past the top
    rb = req_n;
    in_addr = 42'h1000;
    start_op(32'h0, 16'd8, 10'h3FC);
    wait_req(rb + 8);
    chk("t3_last_addr", 512'(req_addr[rb + 7]), 512'(42'h1007));
    d0 = done_n;
    for (int i = 0; i < 7; i++) respond(16'(ord[i]), 16'h3, eRSP_RDLINE);
    tick(2);
    chk("t3_no_early_done", 512'(done_n), 512'(d0));
    respond(16'(ord[7]), 16'h3, eRSP_RDLINE);
    chk("t3_done_early", 512'(op_done), 512'(0));
    tick(1);
    chk("t3_done", 512'(op_done), 512'(1));
    tick(1);
    for (int i = 0; i < 8; i++) begin
      a = 10'h3FC + 10'(i);
      chk("t3_bram", bram[a], pat(16'h3, 16'(i)));
    end
    // back-pressure mid-stream
    rb = req_n;
    in_addr = 42'h4000;
    start_op(32'h0, 16'd6, 10'h80);
    for (int k = 0; k < 50 && req_n < rb + 2; k++) @(negedge clk);
    alm = 1'b1;
    tick(10);
    chk("t4_almfull_hold", 512'(req_n), 512'(rb + 2));
    alm = 1'b0;
    wait_req(rb + 6);
    for (int i = 0; i < 6; i++) chk("t4_addr", 512'(req_addr[rb + i]), 512'(42'h4000 + 42'(i)));
    w0 = wr_n;
    for (int i = 0; i < 6; i++) respond(16'(i), 16'h4, eRSP_RDLINE);
    tick(1);
    chk("t4_done", 512'(op_done), 512'(1));
    chk("t4_writes", 512'(wr_n), 512'(w0 + 6));
    // out_addr selected by regs[0][31]
    rb = req_n;
    start_op(32'h8000_0005, 16'd1, 10'h0);
    wait_req(rb + 1);
    chk("t_out_addr", 512'(req_addr[rb]), 512'(42'h8000_2005));
    respond(16'd0, 16'h5, eRSP_RDLINE);
    tick(1);
    chk("t_out_done", 512'(op_done), 512'(1));
`ifdef PIPEARCH_FETCH_CREDIT_EN
    // in-flight cap with responses withheld
    rb = req_n;
    in_addr = 42'h1000;
    start_op(32'h0, 16'd16, 10'h0);
    tick(30);
    chk("t5_capped", 512'(req_n), 512'(rb + MAXO));
    respond(16'd0, 16'h8, eRSP_RDLINE);
    tick(5);
    chk("t5_release1", 512'(req_n), 512'(rb + MAXO + 1));
    respond(16'd1, 16'h8, eRSP_RDLINE);
    tick(5);
    chk("t5_release2", 512'(req_n), 512'(rb + MAXO + 2));
    for (int i = 2; i < 16; i++) respond(16'(i), 16'h8, eRSP_RDLINE);
    tick(1);
    chk("t5_done", 512'(op_done), 512'(1));
    chk("t5_reqs_total", 512'(req_n), 512'(rb + 16));
`endif
    // reset mid-operation, stale responses afterwards are dropped
    rb = req_n;
    in_addr = 42'h1000;
    start_op(32'h0, 16'd8, 10'h200);
    wait_req(rb + 8);
    w0 = wr_n;
    for (int i = 0; i < 3; i++) respond(16'(i), 16'h6, eRSP_RDLINE);
    tick(1);
    chk("t6_partial_writes", 512'(wr_n), 512'(w0 + 3));
    w0 = wr_n;
    d0 = done_n;
    reset = 1'b0;
    tick(1);
    chk("t6_rst_valid", 512'(tx.valid), 512'(0));
    chk("t6_rst_we", 512'(mem_if.we), 512'(0));
    tick(1);
    reset = 1'b1;
    tick(1);
    for (int i = 3; i < 8; i++) respond(16'(i), 16'h6, eRSP_RDLINE);
    tick(3);
    chk("t6_stale_writes", 512'(wr_n), 512'(w0));
    chk("t6_stale_done", 512'(done_n), 512'(d0));
    rb = req_n;
    in_addr = 42'h0;
    start_op(32'h40, 16'd2, 10'h100);
    wait_req(rb + 2);
    chk("t6_new_addr0", 512'(req_addr[rb]), 512'(42'h40));
    chk("t6_new_addr1", 512'(req_addr[rb + 1]), 512'(42'h41));
    respond(16'd1, 16'h7, eRSP_RDLINE);
    respond(16'd0, 16'h7, eRSP_RDLINE);
    tick(1);
    chk("t6_new_done", 512'(op_done), 512'(1));
    tick(1);
    chk("t6_new_bram0", bram[10'h100], pat(16'h7, 16'd0));
    chk("t6_new_bram1", bram[10'h101], pat(16'h7, 16'd1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
